hp_byte_drain: RTL and testbench



---
 rtl/hp_byte_drain.sv | 119 +++++++++++
 tb/tb_hp_byte_drain.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_byte_drain.sv
// rtl/hp_byte_drain.sv - drains the host-to-parasite byte buffer into a small FIFO
// Presents buffered bytes as a valid/ready stream with a registered interrupt request.
module hp_byte_drain #(
  parameter int DEPTH       = 2,
  parameter int CLR_TIMEOUT = 15
) (
  input  logic        p_phi2,
  input  logic        p_rst,
  input  logic        p_phi2_en,
  input  logic [7:0]  p_data,
  input  logic        p_data_available,
  output logic        p_selectData,
  output logic        p_rdnw,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        irq_en,
  output logic        irq,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] rx_count
);

  typedef enum logic [1:0] {IDLE, READ, WAIT_CLR} state_t;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);
  localparam logic [8:0] TMO_C   = 9'(CLR_TIMEOUT);

  state_t      state;
  logic [7:0]  mem [0:1];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;
  logic [7:0]  timer;
  logic        push;
  logic        pop;
  logic        timeout_hit;

  // With a single entry both pointers stay parked on slot 0.
  function automatic logic ptr_adv(input logic p);
    return (DEPTH == 2) ? ~p : 1'b0;
  endfunction

  assign push        = p_phi2_en && (state == READ);
  assign out_valid   = (fifo_count != 2'd0);
  assign pop         = p_phi2_en && out_valid && out_ready;
  assign out_data    = mem[rd_ptr];
  assign timeout_hit = p_phi2_en && (state == WAIT_CLR) && p_data_available &&
                       (({1'b0, timer} + 9'd1) >= TMO_C);

  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      state        <= IDLE;
      p_selectData <= 1'b0;
      p_rdnw       <= 1'b1;
      mem[0]       <= 8'h00;
      mem[1]       <= 8'h00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      timer        <= 8'd0;
      irq          <= 1'b0;
      err          <= 1'b0;
      rx_count     <= 16'd0;
    end else if (p_phi2_en) begin
      case (state)
        IDLE: begin
          if (p_data_available && (fifo_count < DEPTH_C)) begin
            state        <= READ;
            p_selectData <= 1'b1;
          end
        end
        READ: begin
          state        <= WAIT_CLR;
          p_selectData <= 1'b0;
          timer        <= 8'd0;
        end
        WAIT_CLR: begin
          // Stay put until the buffer flag drops so the same byte is never read twice.
          if (!p_data_available) begin
            state <= IDLE;
            timer <= 8'd0;
          end else if (timeout_hit) begin
            timer <= TMO_C[7:0];
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          p_selectData <= 1'b0;
        end
      endcase

      if (push) begin
        mem[wr_ptr] <= p_data;
        wr_ptr      <= ptr_adv(wr_ptr);
        rx_count    <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= ptr_adv(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      irq <= out_valid & irq_en;

      if (timeout_hit) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hp_byte_drain.sv
// tb/tb_hp_byte_drain.sv - scoreboard bench for hp_byte_drain
// Stimulus pushes expected bytes; a negedge monitor pops and compares on each stream handshake.
module tb_hp_byte_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  data;
  logic        avail;
  logic        sel;
  logic        rdnw;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq_en;
  logic        irq;
  logic        err;
  logic        err_clr;
  logic [15:0] rx_count;

  int checks = 0;
  int errors = 0;
  int sel_clocks = 0;
  int sel_run = 0;
  logic [7:0] exp_q[$];

  hp_byte_drain #(.DEPTH(2), .CLR_TIMEOUT(15)) dut (
    .p_phi2(clk), .p_rst(rst), .p_phi2_en(en), .p_data(data),
    .p_data_available(avail), .p_selectData(sel), .p_rdnw(rdnw),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .irq_en(irq_en), .irq(irq), .err(err), .err_clr(err_clr), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One enabled clock followed by two disabled ones.
  task automatic en3(input int n);
    repeat (n) begin
      en = 1'b1;
      step(1);
      en = 1'b0;
      step(2);
    end
  endtask

  task automatic deliver(input logic [7:0] b);
    data = b;
    avail = 1'b1;
    exp_q.push_back(b);
    step(2);
    avail = 1'b0;
    step(1);
  endtask

  // Stream monitor and protocol watchers.
  always @(negedge clk) begin
    if (sel) sel_clocks++;
    if (!rst && en) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no byte", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
          end
        end
      end
      if (sel) begin
        sel_run++;
        checks++;
        if (sel_run > 1) begin
          errors++;
          $display("FAIL sel_width: got %0d enabled cycles expected 1", sel_run);
        end
      end else begin
        sel_run = 0;
      end
      if (dut.push) begin
        checks++;
        if (dut.fifo_count >= 2'd2) begin
          errors++;
          $display("FAIL push_full: got count %0d expected below 2", dut.fifo_count);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; data = 8'h5A; avail = 1'b1;
    out_ready = 1'b1; irq_en = 1'b0; err_clr = 1'b0;

    // Reset with the buffer flag already raised.
    step(2);
    check("rst_sel", sel, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rx", rx_count, 0);
    check("rst_rdnw", rdnw, 1);
    check("rst_irq", irq, 0);
    check("rst_err", err, 0);
    check("rst_data", out_data, 8'h00);
    exp_q.push_back(8'h5A);
    rst = 1'b0;
    step(1);
    check("post_rst_read", sel, 1);
    step(1);
    check("post_rst_valid", out_valid, 1);
    avail = 1'b0;
    step(3);
    check("post_rst_rx", rx_count, 1);

    // Single byte with interrupt.
    irq_en = 1'b1; data = 8'hA5; avail = 1'b1; exp_q.push_back(8'hA5);
    step(1);
    check("single_sel", sel, 1);
    check("single_valid_early", out_valid, 0);
    step(1);
    check("single_sel_low", sel, 0);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'hA5);
    check("single_irq_early", irq, 0);
    check("single_rx", rx_count, 2);
    step(1);
    check("single_irq", irq, 1);
    check("single_valid_drained", out_valid, 0);
    avail = 1'b0;
    step(1);
    check("single_irq_end", irq, 0);
    step(1);

    // Same byte path with a 1-in-3 clock enable.
    data = 8'hC3; avail = 1'b1; exp_q.push_back(8'hC3); sel_clocks = 0;
    en3(1);
    check("ce_sel", sel, 1);
    en3(1);
    check("ce_valid", out_valid, 1);
    check("ce_irq_early", irq, 0);
    en3(1);
    check("ce_irq", irq, 1);
    check("ce_valid_drained", out_valid, 0);
    avail = 1'b0;
    en3(2);
    en = 1'b1;
    check("ce_sel_clocks", sel_clocks, 3);
    check("ce_rx", rx_count, 3);
    check("ce_irq_end", irq, 0);

    // Back-pressure: third byte waits in IDLE until the FIFO drains.
    irq_en = 1'b0; out_ready = 1'b0;
    deliver(8'h11);
    deliver(8'h22);
    data = 8'h33; avail = 1'b1; exp_q.push_back(8'h33); sel_clocks = 0;
    step(3);
    check("bp_no_read", sel_clocks, 0);
    check("bp_head", out_data, 8'h11);
    check("bp_rx_full", rx_count, 5);
    out_ready = 1'b1;
    step(6);
    avail = 1'b0;
    step(3);
    check("bp_rx", rx_count, 6);
    check("bp_empty", out_valid, 0);

    // Simultaneous push and pop with one entry held.
    out_ready = 1'b0;
    deliver(8'h44);
    data = 8'h55; avail = 1'b1; exp_q.push_back(8'h55);
    step(1);
    check("pp_sel", sel, 1);
    out_ready = 1'b1;
    step(1);
    check("pp_valid", out_valid, 1);
    check("pp_head", out_data, 8'h55);
    avail = 1'b0;
    step(1);
    check("pp_drained", out_valid, 0);
    check("pp_rx", rx_count, 8);
    step(2);

    // Clear timeout: flag stuck high after a read.
    data = 8'h66; avail = 1'b1; exp_q.push_back(8'h66);
    step(2);
    sel_clocks = 0;
    step(14);
    check("tmo_err_early", err, 0);
    step(1);
    check("tmo_err", err, 1);
    step(5);
    check("tmo_err_hold", err, 1);
    check("tmo_no_reread", sel_clocks, 0);
    check("tmo_rx", rx_count, 9);
    avail = 1'b0; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("tmo_err_clr", err, 0);
    data = 8'h77; avail = 1'b1; exp_q.push_back(8'h77);
    step(1);
    check("tmo_idle_read", sel, 1);
    step(1);
    avail = 1'b0;
    step(3);
    check("tmo_rx_after", rx_count, 10);

    // Reset in the middle of a read discards the access.
    data = 8'h88; avail = 1'b1;
    step(1);
    check("abort_sel", sel, 1);
    rst = 1'b1;
    step(1);
    check("abort_sel_low", sel, 0);
    check("abort_valid", out_valid, 0);
    check("abort_rx", rx_count, 0);
    rst = 1'b0; avail = 1'b0;
    step(3);
    check("abort_still_empty", out_valid, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
